// File: rtl/nap_countdown_core.sv
// Nap-machine countdown core: BCD hh:mm:ss load/countdown with pause,
// alarm window with auto-timeout and a bounded snooze budget.
module nap_countdown_core #(
   parameter int CLK_PER_SEC = 1000000,
   parameter int SNOOZE_MIN  = 5,
   parameter int MAX_SNOOZE  = 3,
   parameter int ALARM_SEC   = 60
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [23:0] set_time,
   input  logic        start,
   input  logic        pause,
   input  logic        snooze,
   input  logic        stop,
   output logic [23:0] cur_time,
   output logic [2:0]  state,
   output logic        sec_tick,
   output logic        complete,
   output logic        alarm_on,
   output logic        load_err,
   output logic [3:0]  snooze_left
);

   localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_PER_SEC - 1);
   localparam logic [7:0]    ALARM_LAST  = 8'(ALARM_SEC - 1);
   localparam logic [3:0]    SNOOZE_INIT = 4'(MAX_SNOOZE);
   localparam logic [23:0]   SNOOZE_TIME = {8'h00, 4'(SNOOZE_MIN / 10),
                                            4'(SNOOZE_MIN % 10), 8'h00};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOADED = 3'd1,
      S_RUN    = 3'd2,
      S_PAUSE  = 3'd3,
      S_ALARM  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t        state_q;
   logic [23:0]   time_q;
   logic [PW-1:0] presc_q;
   logic [PW-1:0] alarm_presc_q;
   logic [7:0]    alarm_sec_q;
   logic [3:0]    snooze_left_q;
   logic          sec_tick_q;
   logic          complete_q;
   logic          alarm_on_q;
   logic          load_err_q;

   logic [23:0]   time_dec_d;
   logic          set_valid_d;
   logic          load_state_d;

   function automatic logic time_valid(input logic [23:0] t);
      logic [3:0] h10, h1, m10, m1, s10, s1;
      {h10, h1, m10, m1, s10, s1} = t;
      return (h10 <= 4'd2) && (h1 <= 4'd9) && (m10 <= 4'd5) && (m1 <= 4'd9) &&
             (s10 <= 4'd5) && (s1 <= 4'd9) && !((h10 == 4'd2) && (h1 > 4'd3));
   endfunction

   // Never called with 00:00:00, so a borrow that reaches H1=0 implies H10>0.
   function automatic logic [23:0] bcd_dec(input logic [23:0] t);
      logic [3:0] h10, h1, m10, m1, s10, s1;
      logic       borrow;
      {h10, h1, m10, m1, s10, s1} = t;
      borrow = 1'b1;
      if (s1 == 4'd0) s1 = 4'd9;
      else begin s1 = s1 - 4'd1; borrow = 1'b0; end
      if (borrow) begin
         if (s10 == 4'd0) s10 = 4'd5;
         else begin s10 = s10 - 4'd1; borrow = 1'b0; end
      end
      if (borrow) begin
         if (m1 == 4'd0) m1 = 4'd9;
         else begin m1 = m1 - 4'd1; borrow = 1'b0; end
      end
      if (borrow) begin
         if (m10 == 4'd0) m10 = 4'd5;
         else begin m10 = m10 - 4'd1; borrow = 1'b0; end
      end
      if (borrow) begin
         if (h1 == 4'd0 && h10 != 4'd0) begin
            h1  = 4'd9;
            h10 = h10 - 4'd1;
         end else if (h1 != 4'd0) begin
            h1 = h1 - 4'd1;
         end
      end
      return {h10, h1, m10, m1, s10, s1};
   endfunction

   always_comb begin
      time_dec_d   = bcd_dec(time_q);
      set_valid_d  = time_valid(set_time);
      load_state_d = (state_q == S_IDLE) || (state_q == S_LOADED) ||
                     (state_q == S_PAUSE) || (state_q == S_DONE);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         time_q        <= 24'd0;
         presc_q       <= '0;
         alarm_presc_q <= '0;
         alarm_sec_q   <= 8'd0;
         snooze_left_q <= SNOOZE_INIT;
         sec_tick_q    <= 1'b0;
         complete_q    <= 1'b0;
         alarm_on_q    <= 1'b0;
         load_err_q    <= 1'b0;
      end else begin
         sec_tick_q <= 1'b0;
         complete_q <= 1'b0;
         load_err_q <= 1'b0;
         if (stop) begin
            state_q       <= S_IDLE;
            time_q        <= 24'd0;
            presc_q       <= '0;
            alarm_presc_q <= '0;
            alarm_sec_q   <= 8'd0;
            snooze_left_q <= SNOOZE_INIT;
            alarm_on_q    <= 1'b0;
         end else if (load && load_state_d) begin
            if (set_valid_d) begin
               time_q        <= set_time;
               state_q       <= S_LOADED;
               snooze_left_q <= SNOOZE_INIT;
            end else begin
               load_err_q <= 1'b1;
            end
         end else begin
            unique case (state_q)
               S_LOADED: begin
                  if (start && time_q != 24'd0) begin
                     state_q <= S_RUN;
                     presc_q <= '0;
                  end
               end
               S_PAUSE: begin
                  if (start) state_q <= S_RUN;
               end
               S_RUN: begin
                  if (pause) begin
                     state_q <= S_PAUSE;
                  end else if (presc_q == PRESC_LAST) begin
                     presc_q    <= '0;
                     sec_tick_q <= 1'b1;
                     time_q     <= time_dec_d;
                     if (time_dec_d == 24'd0) begin
                        complete_q    <= 1'b1;
                        state_q       <= S_ALARM;
                        alarm_on_q    <= 1'b1;
                        alarm_presc_q <= '0;
                        alarm_sec_q   <= 8'd0;
                     end
                  end else begin
                     presc_q <= presc_q + 1'b1;
                  end
               end
               S_ALARM: begin
                  if (snooze && snooze_left_q != 4'd0) begin
                     time_q        <= SNOOZE_TIME;
                     snooze_left_q <= snooze_left_q - 4'd1;
                     state_q       <= S_RUN;
                     presc_q       <= '0;
                     alarm_on_q    <= 1'b0;
                  end else if (alarm_presc_q == PRESC_LAST) begin
                     alarm_presc_q <= '0;
                     if (alarm_sec_q == ALARM_LAST) begin
                        state_q     <= S_DONE;
                        alarm_on_q  <= 1'b0;
                        alarm_sec_q <= 8'd0;
                     end else begin
                        alarm_sec_q <= alarm_sec_q + 8'd1;
                     end
                  end else begin
                     alarm_presc_q <= alarm_presc_q + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign cur_time    = time_q;
   assign state       = state_q;
   assign sec_tick    = sec_tick_q;
   assign complete    = complete_q;
   assign alarm_on    = alarm_on_q;
   assign load_err    = load_err_q;
   assign snooze_left = snooze_left_q;

endmodule
